// File: rtl/mem_d1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_d1_rr_arbiter
// Purpose  : Two-client round-robin arbiter sharing a single std_mem_d1.
//            Each access takes IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Revision : 1.0
// ============================================================================
module mem_d1_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [IDX_SIZE-1:0] addr0_i,
  input  logic [IDX_SIZE-1:0] addr1_i,
  input  logic [WIDTH-1:0]    wdata0,
  input  logic [WIDTH-1:0]    wdata1,
  input  logic                we0,
  input  logic                we1,
  output logic [WIDTH-1:0]    rdata0,
  output logic [WIDTH-1:0]    rdata1,
  output logic                done0,
  output logic                done1,
  output logic                grant,
  output logic                busy,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_grant;
  logic                r_last;
  logic                r_we;
  logic                r_mem_we;
  logic [IDX_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic [WIDTH-1:0]    r_rdata0;
  logic [WIDTH-1:0]    r_rdata1;

  logic                w_any_req;
  logic                w_pick;
  logic                w_sel_we;
  logic [IDX_SIZE-1:0] w_sel_addr;
  logic [WIDTH-1:0]    w_sel_wdata;
  logic                w_resp_done;

  // On a tie the client that was not served most recently wins.
  always_comb begin
    w_pick = 1'b0;
    if (req0 && req1) begin
      w_pick = ~r_last;
    end else if (req1) begin
      w_pick = 1'b1;
    end
  end

  assign w_any_req   = req0 | req1;
  assign w_sel_we    = w_pick ? we1     : we0;
  assign w_sel_addr  = w_pick ? addr1_i : addr0_i;
  assign w_sel_wdata = w_pick ? wdata1  : wdata0;

  // Writes wait for the memory acknowledge; a missing one simply stalls RESP.
  assign w_resp_done = (r_state == S_RESP) && (!r_we || mem_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_mem_we <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_pick;
            r_we     <= w_sel_we;
            r_mem_we <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_we <= 1'b0;
          if (!r_we) begin
            if (r_grant) begin
              r_rdata1 <= mem_read_data;
            end else begin
              r_rdata0 <= mem_read_data;
            end
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_done) begin
            r_last  <= r_grant;
            r_addr  <= '0;
            r_wdata <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_mem_we <= 1'b0;
          r_addr   <= '0;
          r_wdata  <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata0         = r_rdata0;
  assign rdata1         = r_rdata1;
  assign done0          = w_resp_done & ~r_grant;
  assign done1          = w_resp_done &  r_grant;
  assign grant          = r_grant;
  assign busy           = (r_state != S_IDLE);
  assign mem_addr0      = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_write_en   = r_mem_we;

  a_done_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(done0 && done1));

  a_we_only_in_access: assert property (@(posedge clk) disable iff (!reset)
    mem_write_en |-> (r_state == S_ACCESS));

endmodule
`default_nettype wire

// File: tb/tb_mem_d1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_d1_rr_arbiter
// Purpose  : Self-checking bench for mem_d1_rr_arbiter with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_mem_d1_rr_arbiter;

  localparam int WIDTH    = 32;
  localparam int IDX_SIZE = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                req0 = 1'b0, req1 = 1'b0;
  logic [IDX_SIZE-1:0] addr0_i = '0, addr1_i = '0;
  logic [WIDTH-1:0]    wdata0 = '0, wdata1 = '0;
  logic                we0 = 1'b0, we1 = 1'b0;
  logic [WIDTH-1:0]    rdata0, rdata1;
  logic                done0, done1, grant, busy;
  logic [IDX_SIZE-1:0] mem_addr0;
  logic [WIDTH-1:0]    mem_write_data;
  logic                mem_write_en;
  logic [WIDTH-1:0]    mem_read_data;
  logic                mem_done;

  mem_d1_rr_arbiter #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .rdata0(rdata0), .rdata1(rdata1),
    .done0(done0), .done1(done1),
    .grant(grant), .busy(busy),
    .mem_addr0(mem_addr0), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_data(mem_read_data),
    .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // Behavioural std_mem_d1: combinational read, write-done the cycle after write_en.
  logic [WIDTH-1:0]    mem [16];
  logic                md_q = 1'b0;
  logic                md_override = 1'b0, md_val = 1'b0;
  logic                pre_en = 1'b0;
  logic [IDX_SIZE-1:0] pre_addr = '0;
  logic [WIDTH-1:0]    pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write_en) mem[mem_addr0] <= mem_write_data;
    md_q <= mem_write_en;
  end
  assign mem_read_data = mem[mem_addr0];
  assign mem_done      = md_override ? md_val : md_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cycles = 0;
  int done0_cnt = 0;
  bit chk_spacing = 1'b0;
  bit have_prev = 1'b0;
  int prev_cyc = 0;

  typedef struct {
    bit          client;
    bit          is_read;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          client;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every done pulse pops the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (mem_write_en) we_cycles++;
    if (done0) done0_cnt++;
    if (reset && (done0 || done1)) begin
      chk("done_exclusive", done0 & done1, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected no done", done0, done1);
      end else begin
        e = sb.pop_front();
        chk("done_client", done1, e.client);
        chk("grant_at_done", grant, e.client);
        if (e.is_read) chk("rdata", e.client ? rdata1 : rdata0, e.rdata);
        if (chk_spacing) begin
          if (have_prev) chk("done_spacing", cyc - prev_cyc, 3);
          prev_cyc  = cyc;
          have_prev = 1'b1;
        end
      end
    end
  end

  task automatic push_exp(input bit c, input bit is_read, input logic [31:0] d);
    exp_t e;
    e.client  = c;
    e.is_read = is_read;
    e.rdata   = d;
    sb.push_back(e);
  endtask

  // Drive one client, hold the request until n done pulses, then drop it.
  task automatic client_req(input bit c, input bit we, input logic [3:0] a,
                            input logic [31:0] d, input int n);
    int cnt = 0;
    if (c) begin
      we1 = we; addr1_i = a; wdata1 = d; req1 = 1'b1;
    end else begin
      we0 = we; addr0_i = a; wdata0 = d; req0 = 1'b1;
    end
    for (int k = 0; k < 40 && cnt < n; k++) begin
      @(negedge clk);
      if ((c && done1) || (!c && done0)) cnt++;
    end
    if (cnt < n) chk(c ? "timeout_done1" : "timeout_done0", cnt, n);
    @(posedge clk);
    #1;
    if (c) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int wc_before;
    int d0_before;
    logic [31:0] other_before;

    vecs[0] = '{1'b1, 1'b1, 4'd7,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 4'd7,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 4'd0,  32'h00000001, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 4'd15, 32'hFFFFFFFF, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 4'd0,  32'h0,        32'h00000001};
    vecs[5] = '{1'b0, 1'b0, 4'd15, 32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b1, 4'd15, 32'h5A5A5A5A, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 4'd15, 32'h0,        32'h5A5A5A5A};
    vecs[8] = '{1'b0, 1'b0, 4'd7,  32'h0,        32'hDEADBEEF};

    // Test 1: reset values, then a single read with exact latency.
    preload(4'd3, 32'h000000A5);
    preload(4'd1, 32'h11111111);
    preload(4'd2, 32'h22222222);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_we", mem_write_en, 0);
    reset = 1'b1;
    @(negedge clk);
    push_exp(1'b0, 1'b1, 32'h000000A5);
    req0 = 1'b1; we0 = 1'b0; addr0_i = 4'd3;
    @(negedge clk);
    chk("t1_access_busy", busy, 1);
    chk("t1_access_nodone", done0, 0);
    @(negedge clk);
    chk("t1_latency_done0", done0, 1);
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    chk("t1_rdata0", rdata0, 32'h000000A5);
    chk("t1_rdata1", rdata1, 0);
    chk("t1_no_write", we_cycles, 0);

    // Test 2: table of single-client accesses, including write/read-back.
    for (int i = 0; i < 9; i++) begin
      wc_before    = we_cycles;
      other_before = vecs[i].client ? rdata0 : rdata1;
      push_exp(vecs[i].client, !vecs[i].we, vecs[i].exp_rdata);
      client_req(vecs[i].client, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1);
      chk("vec_write_pulses", we_cycles - wc_before, {31'b0, vecs[i].we});
      chk("vec_other_rdata", vecs[i].client ? rdata0 : rdata1, other_before);
    end

    // Test 3: tie after reset alternates 0,1,0,1 with 3-cycle spacing.
    do_reset();
    push_exp(1'b0, 1'b1, 32'h11111111);
    push_exp(1'b1, 1'b1, 32'h22222222);
    push_exp(1'b0, 1'b1, 32'h11111111);
    push_exp(1'b1, 1'b1, 32'h22222222);
    chk_spacing = 1'b1; have_prev = 1'b0;
    fork
      client_req(1'b0, 1'b0, 4'd1, 32'h0, 2);
      client_req(1'b1, 1'b0, 4'd2, 32'h0, 2);
    join
    chk_spacing = 1'b0;
    chk("t3_sb_empty", sb.size(), 0);

    // Test 4: client 1 requests while client 0 is in ACCESS.
    @(negedge clk);
    push_exp(1'b0, 1'b1, 32'h000000A5);
    push_exp(1'b1, 1'b1, 32'hDEADBEEF);
    chk_spacing = 1'b1; have_prev = 1'b0;
    fork
      client_req(1'b0, 1'b0, 4'd3, 32'h0, 1);
      begin
        @(negedge clk);
        chk("t4_in_access", busy, 1);
        client_req(1'b1, 1'b0, 4'd7, 32'h0, 1);
      end
    join
    chk_spacing = 1'b0;

    // Test 5: asynchronous reset during a write ACCESS.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0_i = 4'd5; wdata0 = 32'h0BADF00D;
    @(negedge clk);
    chk("t5_access_we", mem_write_en, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_we", mem_write_en, 0);
    chk("t5_async_done0", done0, 0);
    chk("t5_async_busy", busy, 0);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_grant", grant, 0);
    push_exp(1'b0, 1'b1, 32'h000000A5);
    push_exp(1'b1, 1'b1, 32'h11111111);
    chk_spacing = 1'b1; have_prev = 1'b0;
    fork
      client_req(1'b0, 1'b0, 4'd3, 32'h0, 1);
      client_req(1'b1, 1'b0, 4'd1, 32'h0, 1);
      begin
        @(negedge clk);
        chk("t5_tie_grant0", grant, 0);
      end
    join
    chk_spacing = 1'b0;

    // Test 6: stuck mem_done holds RESP; release gives exactly one done.
    @(negedge clk);
    md_override = 1'b1; md_val = 1'b0;
    d0_before = done0_cnt;
    push_exp(1'b0, 1'b0, 32'h0);
    fork
      client_req(1'b0, 1'b1, 4'd9, 32'hCAFEF00D, 1);
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          chk("t6_stuck_busy", busy, 1);
          chk("t6_stuck_nodone", done0, 0);
          if (k < 3) @(negedge clk);
        end
        #1 md_val = 1'b1;
      end
    join
    md_override = 1'b0; md_val = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_one_done", done0_cnt - d0_before, 1);
    chk("t6_idle", busy, 0);
    push_exp(1'b1, 1'b1, 32'hCAFEF00D);
    client_req(1'b1, 1'b0, 4'd9, 32'h0, 1);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
